// File: rtl/bus_wrr_scheduler_pkg.sv
// rtl/bus_wrr_scheduler_pkg.sv - shared types and helpers for the weighted round-robin bus scheduler
package bus_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        POP   = 2'd2,
        PUSH  = 2'd3
    } sched_state_t;

    localparam int ADDR_W = 8;
    localparam int MAX_N  = 256;

    // One-hot vector with bit idx set; all zeros when idx falls outside 0..n-1
    function automatic logic [MAX_N-1:0] onehot(input int idx, input int n);
        logic [MAX_N-1:0] v;
        v = '0;
        if (idx >= 0 && idx < n) begin
            v = MAX_N'(1) << idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/bus_wrr_scheduler_rr_pick_one_hot.sv
// rtl/bus_wrr_scheduler_rr_pick_one_hot.sv - combinational rotate-priority picker starting after last
module rr_pick_one_hot #(
    parameter int n = 5
) (
    input  logic [n-1:0]         req,
    input  logic [$clog2(n)-1:0] last,
    output logic [$clog2(n)-1:0] idx,
    output logic                 any
);
    localparam int W = $clog2(n);

    // Scan from farthest to nearest so the nearest requester after last wins
    always_comb begin
        int c;
        idx = '0;
        any = 1'b0;
        c   = 0;
        for (int k = n; k >= 1; k--) begin
            c = (int'(last) + k) % n;
            if (req[c]) begin
                idx = W'(c);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_wrr_scheduler.sv
// rtl/bus_wrr_scheduler.sv - weighted round-robin packet bus scheduler with destination decode
module bus_wrr_scheduler
    import bus_sched_pkg::*;
#(
    parameter int         drvrs     = 5,
    parameter int         pckg_sz   = 32,
    parameter logic [7:0] broadcast = 8'hFF,
    parameter int         quantum   = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [drvrs-1:0]                pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]                pop,
    output logic [drvrs-1:0]                push,
    output logic [pckg_sz-1:0]              D_push,
    output logic [drvrs-1:0]                grant,
    output logic                            bus_busy,
    output logic                            err_addr
);
    localparam int OW = $clog2(drvrs);
    localparam int CW = $clog2(quantum + 1);

    sched_state_t          state_q, state_d;
    logic [OW-1:0]         owner_q, owner_d;
    logic [OW-1:0]         last_q, last_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [pckg_sz-1:0]    data_q, data_d;

    logic [OW-1:0]         pick_idx;
    logic                  pick_any;
    logic [drvrs-1:0]      owner_oh;
    logic [drvrs-1:0]      dest_oh;
    logic [ADDR_W-1:0]     dest;
    logic                  dest_valid;
    logic                  dest_bcast;
    logic [CW-1:0]         cnt_inc;

    rr_pick_one_hot #(.n(drvrs)) u_pick (
        .req  (pndng),
        .last (last_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign owner_oh   = drvrs'(onehot(int'(owner_q), drvrs));
    assign dest       = data_q[pckg_sz-1 -: ADDR_W];
    assign dest_oh    = drvrs'(onehot(int'(dest), drvrs));
    assign dest_valid = int'(dest) < drvrs;
    assign dest_bcast = (dest == broadcast);
    assign cnt_inc    = cnt_q + CW'(1);

    // State, owner, burst counter and latched packet; reset drops any packet in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OW'(drvrs - 1);
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // Next-state: arbitrate in IDLE, pop once per POP, keep bus until quantum or owner drains
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                state_d = pndng[owner_q] ? POP : IDLE;
            end
            POP: begin
                data_d  = D_pop[owner_q];
                state_d = PUSH;
            end
            PUSH: begin
                cnt_d = cnt_inc;
                if (pndng[owner_q] && (cnt_inc < CW'(quantum))) begin
                    state_d = POP;
                end else begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded purely from registered state, owner and latched packet
    always_comb begin
        grant    = '0;
        pop      = '0;
        push     = '0;
        D_push   = '0;
        err_addr = 1'b0;
        bus_busy = (state_q != IDLE);
        if (state_q != IDLE) begin
            grant = owner_oh;
        end
        if (state_q == POP) begin
            pop = owner_oh;
        end
        if (state_q == PUSH) begin
            D_push = data_q;
            if (dest_valid) begin
                push = dest_oh;
            end else if (dest_bcast) begin
                push = ~owner_oh;
            end else begin
                err_addr = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bus_wrr_scheduler.sv
// tb/tb_bus_wrr_scheduler.sv - directed self-checking bench for bus_wrr_scheduler
module tb_bus_wrr_scheduler;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       pndng;
    logic [4:0][31:0] d_pop;
    logic [4:0]       pop;
    logic [4:0]       push;
    logic [31:0]      d_push;
    logic [4:0]       grant;
    logic             bus_busy;
    logic             err_addr;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [5][8];
    int          rd [5];
    int          wr [5];
    logic [31:0] exp_pkt [$];
    int          exp_src [$];
    int          pop_log [$];
    int          want [$];
    int          ncyc;

    bus_wrr_scheduler #(
        .drvrs     (5),
        .pckg_sz   (32),
        .broadcast (8'hFF),
        .quantum   (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (d_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (d_push),
        .grant    (grant),
        .bus_busy (bus_busy),
        .err_addr (err_addr)
    );

    always #5 clk = ~clk;

    // First-word fall-through FIFO model per device
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            pndng[i] = (rd[i] != wr[i]);
            d_pop[i] = mem[i][rd[i] & 7];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (pop[i]) rd[i] <= rd[i] + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] model_mask(input logic [31:0] pkt, input int src, output bit err);
        logic [7:0] dest;
        dest = pkt[31:24];
        err  = 1'b0;
        if (dest < 8'd5) return 5'b00001 << dest;
        if (dest == 8'hFF) return 5'b11111 & ~(5'b00001 << src);
        err = 1'b1;
        return 5'b00000;
    endfunction

    task automatic load(input int dev, input logic [31:0] pkt);
        mem[dev][wr[dev] & 7] = pkt;
        wr[dev]               = wr[dev] + 1;
    endtask

    // Advance one cycle, then scoreboard pops against deliveries
    task automatic tick();
        int          src;
        logic [31:0] pkt;
        logic [4:0]  m;
        bit          e;
        @(posedge clk);
        #1;
        check("pop_onehot0", {63'd0, $onehot0(pop)}, 64'd1);
        check("pop_push_excl", {63'd0, (pop != 0 && push != 0)}, 64'd0);
        if (pop != 0) begin
            src = 0;
            for (int i = 0; i < 5; i++) if (pop[i]) src = i;
            exp_pkt.push_back(d_pop[src]);
            exp_src.push_back(src);
            pop_log.push_back(src);
        end
        if (push != 0 || err_addr) begin
            if (exp_pkt.size() == 0) begin
                check("unexpected_delivery", {59'd0, push}, 64'd0);
            end else begin
                pkt = exp_pkt.pop_front();
                src = exp_src.pop_front();
                m   = model_mask(pkt, src, e);
                check("sb_push", {59'd0, push}, {59'd0, m});
                check("sb_err", {63'd0, err_addr}, {63'd0, e});
                if (!e) check("sb_data", {32'd0, d_push}, {32'd0, pkt});
            end
        end
    endtask

    task automatic do_reset(input bit clear_fifos);
        reset = 1'b0;
        #1;
        check("rst_grant", {59'd0, grant}, 64'd0);
        check("rst_pop", {59'd0, pop}, 64'd0);
        check("rst_push", {59'd0, push}, 64'd0);
        check("rst_dpush", {32'd0, d_push}, 64'd0);
        check("rst_busy", {63'd0, bus_busy}, 64'd0);
        check("rst_err", {63'd0, err_addr}, 64'd0);
        exp_pkt.delete();
        exp_src.delete();
        pop_log.delete();
        if (clear_fifos) for (int i = 0; i < 5; i++) wr[i] = rd[i];
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic drain(input string tag, output int n);
        bit done;
        done = 1'b0;
        n    = 0;
        while (!done && n < 200) begin
            tick();
            n++;
            if (!bus_busy && pndng == 0) done = 1'b1;
        end
        check(tag, {63'd0, done}, 64'd1);
    endtask

    task automatic check_order(input string tag, input int w[$]);
        check(tag, 64'(pop_log.size()), 64'(w.size()));
        for (int i = 0; i < w.size(); i++) begin
            check(tag, 64'((i < pop_log.size()) ? pop_log[i] : 99), 64'(w[i]));
        end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin
            wr[i] = 0;
            for (int j = 0; j < 8; j++) mem[i][j] = '0;
        end
        reset = 1'b0;
        do_reset(1'b1);

        // Reset mid-transfer, then release with nothing pending
        load(0, 32'h01000011);
        tick();
        tick();
        check("t1_pop", {59'd0, pop}, 64'h01);
        do_reset(1'b1);
        tick();
        tick();
        tick();
        check("t1_idle_busy", {63'd0, bus_busy}, 64'd0);
        check("t1_idle_grant", {59'd0, grant}, 64'd0);

        // Single packet latency from device 2 to device 3
        load(2, 32'h030000AA);
        tick();
        check("t2_grant_c1", {59'd0, grant}, 64'h04);
        check("t2_nopop_c1", {59'd0, pop}, 64'h00);
        tick();
        check("t2_pop_c2", {59'd0, pop}, 64'h04);
        tick();
        check("t2_push_c3", {59'd0, push}, 64'h08);
        check("t2_dpush_c3", {32'd0, d_push}, 64'h030000AA);
        check("t2_grant_c3", {59'd0, grant}, 64'h04);
        tick();
        check("t2_idle", {63'd0, bus_busy}, 64'd0);

        // Broadcast from device 1, bad destination from device 3
        load(1, 32'hFF000001);
        tick();
        tick();
        tick();
        check("t5_bcast_push", {59'd0, push}, 64'h1D);
        check("t5_bcast_err", {63'd0, err_addr}, 64'd0);
        tick();
        load(3, 32'h07000000);
        tick();
        tick();
        tick();
        check("t5_bad_push", {59'd0, push}, 64'h00);
        check("t5_bad_err", {63'd0, err_addr}, 64'd1);
        tick();
        check("t5_err_pulse", {63'd0, err_addr}, 64'd0);

        // Reset during POP: packet stays queued, device 0 wins after release
        do_reset(1'b1);
        load(2, 32'h02000022);
        tick();
        check("t6_grant2", {59'd0, grant}, 64'h04);
        load(0, 32'h04000033);
        tick();
        check("t6_pop2", {59'd0, pop}, 64'h04);
        do_reset(1'b0);
        tick();
        check("t6_first_grant", {59'd0, grant}, 64'h01);
        drain("t6_drain", ncyc);
        want = '{0, 2};
        check_order("t6_order", want);
        check("t6_dev2_empty", 64'(rd[2]), 64'(wr[2]));

        // Every device with two packets: bursts of two in order 0..4
        do_reset(1'b1);
        for (int d = 0; d < 5; d++) begin
            for (int k = 0; k < 2; k++) begin
                if (d == 0 && k == 0)      load(d, {8'hFF, 8'h00, 8'(d), 8'(k)});
                else if (d == 4 && k == 1) load(d, {8'h10, 8'h00, 8'(d), 8'(k)});
                else                       load(d, {8'((d + k + 1) % 5), 8'h00, 8'(d), 8'(k)});
            end
        end
        drain("t3_drain", ncyc);
        check("t3_cycles", 64'(ncyc), 64'd30);
        want = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4};
        check_order("t3_order", want);

        // Quantum limit: device 0 yields after 4 packets
        do_reset(1'b1);
        for (int k = 0; k < 6; k++) load(0, {8'((k + 1) % 5), 16'h0, 8'(k)});
        load(1, 32'h00000100);
        drain("t4_drain", ncyc);
        check("t4_cycles", 64'(ncyc), 64'd20);
        want = '{0, 0, 0, 0, 1, 0, 0};
        check_order("t4_order", want);

        check("sb_all_delivered", 64'(exp_pkt.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
